// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-SRAM responder: byte-enable masks,
// mask legality, address range check and read-latency bounds.
package data_sram_resp_pkg;

   localparam logic [3:0] WEN_RD   = 4'b0000;
   localparam logic [3:0] WEN_B0   = 4'b0001;
   localparam logic [3:0] WEN_B1   = 4'b0010;
   localparam logic [3:0] WEN_B2   = 4'b0100;
   localparam logic [3:0] WEN_B3   = 4'b1000;
   localparam logic [3:0] WEN_H0   = 4'b0011;
   localparam logic [3:0] WEN_H1   = 4'b1100;
   localparam logic [3:0] WEN_MID  = 4'b0110;
   localparam logic [3:0] WEN_SWL3 = 4'b0111;
   localparam logic [3:0] WEN_SWR1 = 4'b1110;
   localparam logic [3:0] WEN_W    = 4'b1111;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } rd_beat_t;

   // Only contiguous lane groups are legal; a read mask is not a write mask.
   function automatic logic wen_legal(input logic [3:0] wen);
      case (wen)
         WEN_B0, WEN_B1, WEN_B2, WEN_B3,
         WEN_H0, WEN_H1, WEN_MID,
         WEN_SWL3, WEN_SWR1, WEN_W: wen_legal = 1'b1;
         default:                   wen_legal = 1'b0;
      endcase
   endfunction

   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input int unsigned addr_w,
                                          input logic [31:0] base_hi);
      addr_in_range = ((addr >> (addr_w + 32'd2)) == base_hi);
   endfunction

endpackage

// File: rtl/data_sram_resp_sram_rd_pipe.sv
// Fixed-depth {valid, data} shift pipeline; each stage keeps its data while
// no valid beat passes, so the last stage holds rdata between pulses.
module sram_rd_pipe
   import data_sram_resp_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic     clk,
   input  logic     reset,
   input  rd_beat_t i_beat,
   output rd_beat_t o_beat
);

   rd_beat_t r_stage [LAT];

   // Advance beats one stage per clock; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < LAT; s++) begin
            r_stage[s] <= '0;
         end
      end else begin
         r_stage[0].valid <= i_beat.valid;
         if (i_beat.valid) begin
            r_stage[0].data <= i_beat.data;
         end
         for (int s = 1; s < LAT; s++) begin
            r_stage[s].valid <= r_stage[s-1].valid;
            if (r_stage[s-1].valid) begin
               r_stage[s].data <= r_stage[s-1].data;
            end
         end
      end
   end

   assign o_beat = r_stage[LAT-1];

endmodule

// File: rtl/data_sram_resp.sv
// Responder end of the CPU data-SRAM port: byte-lane writes into a word
// array, fixed-latency reads, illegal-request flag and access counters.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int          ADDR_W  = 12,
   parameter logic [31:0] BASE_HI = 32'h0,
   parameter int          RD_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        data_sram_rvalid,
   output logic        req_err,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("data_sram_resp: RD_LAT out of range");
   end

   logic [31:0]       r_mem [DEPTH];
   logic              r_req_err;
   logic [31:0]       r_rd_cnt;
   logic [31:0]       r_wr_cnt;

   logic [ADDR_W-1:0] w_idx;
   logic              w_in_range;
   logic              w_is_rd;
   logic              w_wr_ok;
   logic              w_rd_ok;
   logic              w_err;
   rd_beat_t          w_beat_in;
   rd_beat_t          w_beat_out;

   // Decode the request; reset-cycle requests are dropped entirely.
   always_comb begin
      w_idx      = data_sram_addr[ADDR_W+1:2];
      w_in_range = addr_in_range(data_sram_addr, ADDR_W, BASE_HI);
      w_is_rd    = (data_sram_wen == WEN_RD);
      w_wr_ok    = data_sram_en && !reset && !w_is_rd && w_in_range
                   && wen_legal(data_sram_wen);
      w_rd_ok    = data_sram_en && !reset && w_is_rd && w_in_range;
      w_err      = data_sram_en && (!w_in_range
                   || (!w_is_rd && !wen_legal(data_sram_wen)));
      w_beat_in.valid = data_sram_en && w_is_rd;
      if (w_in_range) begin
         w_beat_in.data = r_mem[w_idx];
      end else begin
         w_beat_in.data = 32'h0;
      end
   end

   // Byte-lane write; the read path above still sees the pre-edge word.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         for (int k = 0; k < 4; k++) begin
            if (data_sram_wen[k]) begin
               r_mem[w_idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
            end
         end
      end
   end

   // Error pulse and free-running wrap-around access counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_err <= 1'b0;
         r_rd_cnt  <= 32'h0;
         r_wr_cnt  <= 32'h0;
      end else begin
         r_req_err <= w_err;
         if (w_rd_ok) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
         end
         if (w_wr_ok) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
         end
      end
   end

   sram_rd_pipe #(
      .LAT (RD_LAT)
   ) u_rd_pipe (
      .clk    (clk),
      .reset  (reset),
      .i_beat (w_beat_in),
      .o_beat (w_beat_out)
   );

   assign data_sram_rdata  = w_beat_out.data;
   assign data_sram_rvalid = w_beat_out.valid;
   assign req_err          = r_req_err;
   assign rd_cnt           = r_rd_cnt;
   assign wr_cnt           = r_wr_cnt;

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomized self-checking bench for data_sram_resp against a cycle-level
// reference model of the memory, read schedule, error flag and counters.
module tb_data_sram_resp;

   localparam int          ADDR_W  = 12;
   localparam logic [31:0] BASE_HI = 32'h0;
   localparam int          RD_LAT  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        req_err;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   always #5 clk = ~clk;

   data_sram_resp #(
      .ADDR_W  (ADDR_W),
      .BASE_HI (BASE_HI),
      .RD_LAT  (RD_LAT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .data_sram_en     (en),
      .data_sram_wen    (wen),
      .data_sram_addr   (addr),
      .data_sram_wdata  (wdata),
      .data_sram_rdata  (rdata),
      .data_sram_rvalid (rvalid),
      .req_err          (req_err),
      .rd_cnt           (rd_cnt),
      .wr_cnt           (wr_cnt)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_mem [int];
   bit          pend_v [0:7];
   logic [31:0] pend_d [0:7];
   int          t = 0;
   logic [31:0] e_rdata = 32'h0;
   logic        e_rvalid = 1'b0;
   logic        e_err = 1'b0;
   logic [31:0] e_rd = 32'h0;
   logic [31:0] e_wr = 32'h0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0d)", tag, act, exp, t);
      end
   endtask

   // A write mask is legal when its set bits form one non-empty run.
   function automatic bit contiguous(input logic [3:0] m);
      logic [3:0] x;
      if (m == 4'd0) return 1'b0;
      x = m;
      while (!x[0]) x = x >> 1;
      return ((x & (x + 4'd1)) == 4'd0);
   endfunction

   task automatic model_edge();
      bit inr;
      int idx;
      int slot;
      if (reset) begin
         for (int i = 0; i < 8; i++) pend_v[i] = 1'b0;
         e_rdata  = 32'h0;
         e_rvalid = 1'b0;
         e_err    = 1'b0;
         e_rd     = 32'h0;
         e_wr     = 32'h0;
      end else begin
         inr   = ((addr >> (ADDR_W + 2)) == BASE_HI);
         idx   = int'(addr[ADDR_W+1:2]);
         e_err = en && (!inr || (wen != 4'd0 && !contiguous(wen)));
         if (en && wen == 4'd0) begin
            slot = (t + RD_LAT - 1) % 8;
            pend_v[slot] = 1'b1;
            pend_d[slot] = inr ? m_mem[idx] : 32'h0;
            if (inr) e_rd = e_rd + 32'd1;
         end
         if (en && wen != 4'd0 && inr && contiguous(wen)) begin
            for (int k = 0; k < 4; k++)
               if (wen[k]) m_mem[idx][8*k +: 8] = wdata[8*k +: 8];
            e_wr = e_wr + 32'd1;
         end
         e_rvalid = pend_v[t % 8];
         if (e_rvalid) e_rdata = pend_d[t % 8];
         pend_v[t % 8] = 1'b0;
      end
      t++;
   endtask

   task automatic cyc(input logic r, input logic e, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d);
      reset = r; en = e; wen = w; addr = a; wdata = d;
      @(posedge clk);
      model_edge();
      #1;
      check_eq("rvalid",  {31'd0, rvalid},  {31'd0, e_rvalid});
      check_eq("rdata",   rdata,            e_rdata);
      check_eq("req_err", {31'd0, req_err}, {31'd0, e_err});
      check_eq("rd_cnt",  rd_cnt,           e_rd);
      check_eq("wr_cnt",  wr_cnt,           e_wr);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 4'd0, $urandom, $urandom);
   endtask

   task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] v);
      cyc(1'b0, 1'b1, 4'd0, a, $urandom);
      repeat (RD_LAT - 1) idle();
      check_eq({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
      check_eq(tag, rdata, v);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; wen = 4'd0; addr = 32'h0; wdata = 32'h0;

      // Reset for three cycles, then quiet cycles with nothing pending
      repeat (3) cyc(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
      repeat (3) idle();
      check_eq("rst_rdata", rdata, 32'h0);
      check_eq("rst_rd_cnt", rd_cnt, 32'h0);

      // Preload words 0..31 so every in-range random read has a known value
      for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 4'hF, i * 4, $urandom);

      // Word write then read, partial lane writes
      cyc(1'b0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
      read_expect("word_rd", 32'h10, 32'hDEADBEEF);
      cyc(1'b0, 1'b1, 4'b0001, 32'h10, 32'h000000AA);
      read_expect("sb_rd", 32'h10, 32'hDEADBEAA);
      cyc(1'b0, 1'b1, 4'b1100, 32'h10, 32'h55660000);
      read_expect("sh_rd", 32'h10, 32'h5566BEAA);
      cyc(1'b0, 1'b1, 4'b0111, 32'h13, 32'h00112233);
      read_expect("swl_rd", 32'h10, 32'h55112233);

      // Illegal mask and out-of-range read
      cyc(1'b0, 1'b1, 4'b0101, 32'h10, 32'hFFFFFFFF);
      check_eq("illegal_err", {31'd0, req_err}, 32'd1);
      read_expect("illegal_kept", 32'h10, 32'h55112233);
      cyc(1'b0, 1'b1, 4'b0000, 32'h0001_0010, 32'h0);
      check_eq("oor_err", {31'd0, req_err}, 32'd1);
      repeat (RD_LAT - 1) idle();
      check_eq("oor_rvalid", {31'd0, rvalid}, 32'd1);
      check_eq("oor_rdata", rdata, 32'h0);

      // Write followed immediately by read, then a streaming burst
      cyc(1'b0, 1'b1, 4'b1111, 32'h20, 32'h11111111);
      read_expect("raw_rd", 32'h20, 32'h11111111);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 4'd0, 32'h40 + i * 4, 32'h0);
      repeat (RD_LAT) idle();

      // Reset with two reads in flight and a write presented during reset
      cyc(1'b0, 1'b1, 4'd0, 32'h4, 32'h0);
      cyc(1'b0, 1'b1, 4'd0, 32'h8, 32'h0);
      cyc(1'b1, 1'b1, 4'hF, 32'h4, 32'hCAFEF00D);
      repeat (RD_LAT) idle();
      check_eq("midrst_rd_cnt", rd_cnt, 32'h0);
      check_eq("midrst_wr_cnt", wr_cnt, 32'h0);
      read_expect("midrst_nowrite", 32'h4, m_mem[1]);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [3:0]  w;
         logic [31:0] a;
         w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
         if ($urandom_range(0, 99) < 85)
            a = {25'd0, 5'($urandom), 2'($urandom)};
         else
            a = $urandom | 32'h0000_4000;
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), w, a, $urandom);
      end
      repeat (RD_LAT) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the CPU data-SRAM interface. It serves the byte-enable load/store requests issued by the MEM stage, including SB/SH/SW and the SWL/SWR partial-word masks.
- Holds a word-addressed storage array and applies byte-lane writes in the request cycle.
- Returns read data through a configurable-latency pipeline with a valid strobe.
- Flags illegal requests and keeps access counters for the verification harness. Sits between the CPU core and the testbench memory image.

Parameters:
- ADDR_W, 12, word-index width; depth = 2**ADDR_W words.
- BASE_HI, 18'h0, required value of addr[31:ADDR_W+2]; other addresses are out of range.
- RD_LAT, 1, read latency in cycles, legal 1..4.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_sram_en  in  1  request valid this cycle.
- data_sram_wen  in  4  byte write enables; 4'b0000 = read.
- data_sram_addr  in  32  byte address; bits [1:0] ignored for array indexing.
- data_sram_wdata  in  32  write data, already lane-aligned by the requester.
- data_sram_rdata  out  32  read data.
- data_sram_rvalid  out  1  one-cycle pulse, rdata valid.
- req_err  out  1  one-cycle pulse: illegal wen mask or out-of-range address.
- rd_cnt  out  32  count of accepted reads.
- wr_cnt  out  32  count of accepted writes.

Behaviour:
- Reset (synchronous, active-high): rdata=0, rvalid=0, req_err=0, rd_cnt=0, wr_cnt=0, all read-pipeline valid bits cleared. Array contents are not reset.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them. A request presented in a reset cycle is ignored: no write, no count.
- A request is accepted in every cycle with en=1 and reset=0; there is no back-pressure. en=0 is a no-op.
- Range check: in_range = (addr[31:ADDR_W+2]==BASE_HI). Index = addr[ADDR_W+1:2].
- Legal write masks, all contiguous: 0001, 0010, 0100, 1000, 0011, 0110, 1100, 0111, 1110, 1111.
- Illegal masks: 0101, 1001, 1010, 1011, 1101.
- Write (wen!=0):
  - If the mask is legal and in_range: at the clock edge, array[idx] byte k <= wdata byte k for every set wen[k]; other bytes are unchanged. wr_cnt += 1.
  - Otherwise: no array change, no count, req_err=1 in the next cycle.
  - Writes never produce rvalid.
- Read (wen==0):
  - The array word is sampled at the accept edge; read-before-write applies only to the same edge.
  - A read accepted in cycle N asserts rvalid in cycle N+RD_LAT with rdata = that word.
  - Out-of-range read: rdata=0, rvalid still asserted at N+RD_LAT, req_err=1 at N+1. rd_cnt increments for in-range reads only.
- Ordering: a write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- Back-to-back reads every cycle give rvalid every cycle, in order.
- rdata holds its last value while rvalid=0.
- Counters wrap at 2**32 with no saturation.
- req_err and rvalid are independent. Both can be 1 in the same cycle.

Decomposition:
- Shared package:
  - WEN_* mask constants: WEN_B0..WEN_B3, WEN_H0, WEN_H1, WEN_SWL/SWR patterns, WEN_W.
  - wen_legal function over the 4-bit mask.
  - Range-check function.
  - RD_LAT bounds.
- Sub-module: sram_rd_pipe, an RD_LAT-deep shift pipeline of {valid, data} with synchronous clear. The top instantiates it after the array read port.

Test Plan:
1. Reset: hold reset for 3 cycles, then release -> rdata=0, rvalid=0, rd_cnt=wr_cnt=0; no pulses while en=0.
2. Word write then read: write 0xDEADBEEF, wen 1111, addr 0x10; read addr 0x10 next cycle, RD_LAT=2 -> rvalid 2 cycles after the read with rdata=0xDEADBEEF; wr_cnt=1, rd_cnt=1.
3. Partial writes on that word:
   - wen 0001 wdata 0x000000AA -> word 0xDEADBEAA.
   - Then wen 1100 wdata 0x55660000 -> word 0x5566BEAA.
   - Then wen 0111 wdata 0x00112233 -> word 0x55112233.
4. Illegal and out-of-range:
   - wen 0101 -> req_err pulse at N+1, word unchanged, wr_cnt unchanged.
   - Read addr with upper bits != BASE_HI -> rdata=0 with rvalid, req_err at N+1, rd_cnt unchanged.
5. Same-edge write and read plus streaming:
   - Write 0x11111111 to addr 0x20 in cycle N, read 0x20 in cycle N+1 -> 0x11111111.
   - 8 back-to-back reads of distinct preloaded words -> 8 consecutive rvalid pulses in order.
6. Reset mid-flight: RD_LAT=3; issue reads in cycles N and N+1, assert reset at N+2 -> no rvalid at N+3 or N+4; counters = 0.
